// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with an 8-entry TX FIFO and a programmable baud divisor.
// Optional MMIO_TX_IRQ_EN adds a one-cycle "FIFO drained" irq and the STATUS[6] idle flag.
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR  = 16'hC004,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] RESET_DIV  = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        tx
`ifdef MMIO_TX_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [15:0]   ADDR_DATA = BASE_ADDR;
    localparam logic [15:0]   ADDR_STAT = BASE_ADDR + 16'd1;
    localparam logic [15:0]   ADDR_DIV  = BASE_ADDR + 16'd2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     div_q, div_d, bit_cnt_q, bit_cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            ovf_q, ovf_d, tx_q, tx_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef MMIO_TX_IRQ_EN
    logic            irq_q, irq_d;
`endif

    logic        hit_data, hit_stat, hit_div;
    logic        fifo_empty, fifo_full, push_req, push_ok, pop, bit_done, busy, idle_flag;
    logic [15:0] div_eff;
    logic [3:0]  free4;

    always_comb begin
        hit_data   = (addr == ADDR_DATA);
        hit_stat   = (addr == ADDR_STAT);
        hit_div    = (addr == ADDR_DIV);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == DEPTH_C);
        push_req   = we && hit_data;
        div_eff    = (div_q == 16'd0) ? 16'd1 : div_q;
        bit_done   = (bit_cnt_q == 16'd0);
        busy       = (state_q != S_IDLE) || !fifo_empty;
        free4      = 4'(DEPTH_C - count_q);
`ifdef MMIO_TX_IRQ_EN
        idle_flag  = (state_q == S_IDLE) && fifo_empty;
`else
        idle_flag  = 1'b0;
`endif
    end

    // The bit counter is reloaded from the divisor only at bit boundaries,
    // so a divisor write never stretches or cuts the bit in progress.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_done ? 16'd0 : bit_cnt_q - 16'd1;
        idx_d     = idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
`ifdef MMIO_TX_IRQ_EN
        irq_d     = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = div_eff - 16'd1;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    bit_cnt_d = div_eff - 16'd1;
                    idx_d     = 3'd0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = div_eff - 16'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
                        bit_cnt_d = div_eff - 16'd1;
                        state_d   = S_START;
                    end else begin
                        state_d = S_IDLE;
`ifdef MMIO_TX_IRQ_EN
                        irq_d   = 1'b1;
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_q)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_q[idx_q];
            default: tx_d = 1'b1;
        endcase
    end

    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    always_comb begin
        push_ok  = push_req && (!fifo_full || pop);
        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
        ovf_d = ovf_q;
        if (we && hit_stat && wdata[5]) begin
            ovf_d = 1'b0;
        end
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
        div_d = (we && hit_div) ? wdata : div_q;
    end

    always_comb begin
        rdata = 16'h0000;
        if (re && hit_stat) begin
            rdata = {9'b0, idle_flag, ovf_q, busy, free4};
        end else if (re && hit_div) begin
            rdata = div_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            div_q     <= RESET_DIV;
            bit_cnt_q <= 16'd0;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
            ovf_q     <= 1'b0;
            tx_q      <= 1'b1;
`ifdef MMIO_TX_IRQ_EN
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            ovf_q     <= ovf_d;
            tx_q      <= tx_d;
`ifdef MMIO_TX_IRQ_EN
            irq_q     <= irq_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    assign tx = tx_q;
`ifdef MMIO_TX_IRQ_EN
    assign irq = irq_q;
`endif

endmodule
